// File: rtl/seq_digit_mul_pkg.sv
// Shared definitions for the sequential digit-serial multiplier.
//   DIGIT_W : width of one operand digit fed to the 2x2 multiplier
//   state_e : controller states IDLE / CALC / DONE
package seq_digit_mul_pkg;

  localparam int unsigned DIGIT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_digit_mul_x2_accu_mul.sv
// 2-bit x 2-bit exact unsigned multiplier (pure combinational).
//   a, b : 2-bit operands
//   p    : 4-bit product a*b
module x2_accu_mul (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);

  logic a0b0, a1b0, a0b1, a1b1;

  always_comb begin
    a0b0 = a[0] & b[0];
    a1b0 = a[1] & b[0];
    a0b1 = a[0] & b[1];
    a1b1 = a[1] & b[1];
    p[0] = a0b0;
    p[1] = a1b0 ^ a0b1;
    // carry out of bit 1 feeds bit 2; it can only be set when all four bits are 1
    p[2] = a1b1 ^ (a1b0 & a0b1);
    p[3] = a1b1 & a1b0 & a0b1;
  end

endmodule

// File: rtl/seq_digit_mul.sv
// Sequential unsigned multiplier that processes one pair of 2-bit digits per
// cycle through a single 2x2 multiplier, accumulating shifted partial products.
//   clk, resetn         : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready only in IDLE)
//   a, b                : WIDTH-bit unsigned operands
//   out_valid/out_ready : result handshake (result held while out_ready low)
//   product             : 2*WIDTH-bit result a*b
//   busy                : high while calculating or holding a result
module seq_digit_mul
  import seq_digit_mul_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int unsigned D     = WIDTH / DIGIT_W;
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned IDX_W = (D > 1) ? $clog2(D) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(D - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [IDX_W-1:0]     i_q, i_d;   // a-digit index (upper counter half)
  logic [IDX_W-1:0]     j_q, j_d;   // b-digit index (lower counter half)
  logic [PW-1:0]        acc_q, acc_d;
  logic                 out_valid_q, out_valid_d;

  logic [DIGIT_W-1:0]   a_dig, b_dig;
  logic [2*DIGIT_W-1:0] pp;

  x2_accu_mul u_mul (
    .a (a_dig),
    .b (b_dig),
    .p (pp)
  );

  always_comb begin
    a_dig = DIGIT_W'(a_q >> (DIGIT_W * i_q));
    b_dig = DIGIT_W'(b_q >> (DIGIT_W * j_q));
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    i_d         = i_q;
    j_d         = j_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d = acc_q + (PW'(pp) << (DIGIT_W * (i_q + j_q)));
        // counter walks j fastest, then i; wrapping at D-1 keeps this correct
        // even when D is not a power of two
        if (j_q == LAST_IDX) begin
          j_d = '0;
          if (i_q == LAST_IDX) begin
            i_d         = '0;
            state_d     = ST_DONE;
            out_valid_d = 1'b1;
          end else begin
            i_d = i_q + IDX_W'(1);
          end
        end else begin
          j_d = j_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      i_q         <= i_d;
      j_q         <= j_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    out_valid = out_valid_q;
    product   = acc_q;
  end

endmodule

// File: doc/seq_digit_mul.md
SEQ_DIGIT_MUL -- requirements
Module: seq_digit_mul

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving operand width in bits; it must be even and at least 2.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit, meaning operands a/b are offered.
REQ-005 SHALL have port in_ready, output, 1 bit, meaning the block accepts operands this cycle.
REQ-006 SHALL have ports a and b, input, WIDTH bits each, the unsigned operands.
REQ-007 SHALL have port out_valid, output, 1 bit, meaning product holds a finished result.
REQ-008 SHALL have port out_ready, input, 1 bit, meaning the consumer takes the result this cycle.
REQ-009 SHALL have port product, output, 2*WIDTH bits, the unsigned result a*b.
REQ-010 SHALL have port busy, output, 1 bit, high in CALC and DONE.

Function
REQ-011 SHALL implement states IDLE, CALC and DONE.
REQ-012 SHALL drive in_ready high only in IDLE; the accept handshake is in_valid && in_ready at a rising edge.
REQ-013 On accept, SHALL latch a and b, clear the accumulator, clear the digit counter and enter CALC.
REQ-014 SHALL split each operand into D = WIDTH/2 two-bit digits and iterate over all D*D pairs, one pair per CALC cycle; for WIDTH=8 that is 16 cycles.
REQ-015 SHALL take counter bits as i (a-digit index, upper half) and j (b-digit index, lower half).
REQ-016 Each CALC cycle, SHALL form the 4-bit partial product of a-digit i and b-digit j through one 2x2 multiplier.
REQ-017 SHALL add that partial product, shifted left by 2*(i+j), into a 2*WIDTH-bit accumulator; no overflow is possible and no carry is dropped.
REQ-018 When the counter equals D*D-1 at a CALC edge, SHALL perform that final accumulation, enter DONE and assert out_valid on the same edge.
REQ-019 Latency SHALL be exactly D*D rising edges from the accept edge to the first edge at which out_valid is high: 16 for WIDTH=8.
REQ-020 product SHALL equal the accumulator at all times; it is defined only while out_valid is high.
REQ-021 In DONE, SHALL hold out_valid and product stable while out_ready is low, for any number of cycles.
REQ-022 On out_valid && out_ready, SHALL deassert out_valid and return to IDLE; in_ready rises the following cycle.
REQ-023 SHALL not accept a new operand in the cycle the result is consumed.
REQ-024 SHALL ignore in_valid, a and b outside IDLE; latched operands SHALL NOT change during CALC.
REQ-025 SHALL make out_ready in IDLE or CALC have no effect.

Reset
REQ-026 On resetn low, SHALL immediately enter IDLE and force out_valid=0, busy=0, product=0 and counter=0; in_ready=1.
REQ-027 Reset mid-CALC or in DONE SHALL discard the operation; no result is later presented.
REQ-028 SHALL resume normal operation at the first rising clock edge after resetn deasserts.

Structure
REQ-029 SHALL place the state encoding (IDLE, CALC, DONE) and the digit width constant (2) in a shared package.
REQ-030 SHALL instantiate the team's 2-bit accurate multiplier x2_accu_mul exactly once as its only sub-module.
REQ-031 SHALL register all outputs except in_ready and busy, which are decoded from state.

Verification
REQ-032 Accept a=255, b=255 -> out_valid high 16 edges later; product=0xFE01 (65025).
REQ-033 Accept a=0, b=173 -> product=0; accept a=1, b=200 -> product=200.
REQ-034 Accept a=13, b=11, hold out_ready low 5 cycles -> product=143 held stable; consumed on the 6th cycle; in_ready high the next cycle.
REQ-035 Toggle in_valid with differing a/b during CALC -> ignored; the result matches the first accepted pair.
REQ-036 Assert resetn low at CALC cycle 7 -> outputs cleared at once; after release, accept 3*3 -> product=9, no stale result.
REQ-037 Run 1000 random back-to-back pairs with random out_ready stalls -> every product matches a*b; one result per accept.
